issue_scoreboard: RTL and testbench

//  In-order issue controller between decode and execute units. Classifies each 32-bit instruction by opcode
//  (same opcode set as the immediate extender), tracks pending register writes in a 32-bit scoreboard,

---
 rtl/issue_scoreboard_if.sv | 29 ++
 rtl/issue_scoreboard.sv | 156 +++++++++++++++
 tb/tb_issue_scoreboard.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Issue scoreboard bus: decode handshake, issue handshake, writeback/LSU completion,
// flush, and scoreboard status.
//   master : decode/execute side (drives dec_*, iss_ready, wb_*, lsu_done, flush)
//   slave  : issue_scoreboard (drives dec_ready, iss_*, sb_pending, sb_busy)
interface issue_scoreboard_if;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic        dec_ready;
  logic        iss_valid;
  logic [31:0] iss_instr;
  logic [1:0]  iss_fu;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        lsu_done;
  logic        flush;
  logic [31:0] sb_pending;
  logic        sb_busy;

  modport master (
    output dec_valid, dec_instr, iss_ready, wb_valid, wb_rd, lsu_done, flush,
    input  dec_ready, iss_valid, iss_instr, iss_fu, sb_pending, sb_busy
  );

  modport slave (
    input  dec_valid, dec_instr, iss_ready, wb_valid, wb_rd, lsu_done, flush,
    output dec_ready, iss_valid, iss_instr, iss_fu, sb_pending, sb_busy
  );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue controller between decode and execute.
// Classifies each instruction by opcode, tracks in-flight register writes in a scoreboard,
// stalls on RAW/WAW/LSU-busy hazards and presents accepted instructions through a single
// registered issue stage. A flush discards the issue stage and drains all in-flight work
// before issue resumes.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus_io  : issue_scoreboard_if.slave
//     dec_valid/dec_instr/dec_ready   decode handshake
//     iss_valid/iss_instr/iss_fu/iss_ready  issue handshake (fu: 00 ALU 01 LSU 10 BR 11 illegal)
//     wb_valid/wb_rd                  writeback clears pending bit
//     lsu_done                        clears LSU busy
//     flush                           discard issue stage, drain
//     sb_pending/sb_busy              scoreboard status
//
// Optional feature: define SB_BYPASS_EN to let same-cycle writeback / lsu_done release
// hazards and DRAIN exit one cycle earlier.
module issue_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned FU_W = 2
) (
  input logic                clk,
  input logic                rst,
  issue_scoreboard_if.slave  bus_io
);

  localparam logic [FU_W-1:0] FuAlu = FU_W'(0);
  localparam logic [FU_W-1:0] FuLsu = FU_W'(1);
  localparam logic [FU_W-1:0] FuBr  = FU_W'(2);
  localparam logic [FU_W-1:0] FuIll = FU_W'(3);

  typedef enum logic {StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              lsu_busy_q, lsu_busy_d;
  logic              iss_valid_q, iss_valid_d;
  logic [31:0]       iss_instr_q, iss_instr_d;
  logic [FU_W-1:0]   iss_fu_q, iss_fu_d;

  // Instruction decode
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic            use_rs1, use_rs2, use_rd, is_lsu;
  logic [FU_W-1:0] fu;

  assign opcode = bus_io.dec_instr[6:0];
  assign rd     = bus_io.dec_instr[11:7];
  assign rs1    = bus_io.dec_instr[19:15];
  assign rs2    = bus_io.dec_instr[24:20];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    is_lsu  = 1'b0;
    fu      = FuIll;
    case (opcode)
      7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; fu = FuAlu; end
      7'b0010011: begin use_rs1 = 1'b1; use_rd = 1'b1; fu = FuAlu; end
      7'b0000011: begin use_rs1 = 1'b1; use_rd = 1'b1; is_lsu = 1'b1; fu = FuLsu; end
      7'b0100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_lsu = 1'b1; fu = FuLsu; end
      7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; fu = FuBr; end
      7'b1101111: begin use_rd = 1'b1; fu = FuBr; end
      7'b1100111: begin use_rs1 = 1'b1; use_rd = 1'b1; fu = FuBr; end
      7'b0110111,
      7'b0010111: begin use_rd = 1'b1; fu = FuAlu; end
      default: ;
    endcase
  end

  // Writeback clear mask; x0 is never pending so clearing it is harmless
  logic [NREG-1:0] wb_clr;
  assign wb_clr = bus_io.wb_valid ? (NREG'(1) << bus_io.wb_rd) : '0;

  // State the hazard check and drain exit look at
  logic [NREG-1:0] pend_eff;
  logic            lsu_eff;
`ifdef SB_BYPASS_EN
  assign pend_eff = pending_q & ~wb_clr;
  assign lsu_eff  = lsu_busy_q & ~bus_io.lsu_done;
`else
  assign pend_eff = pending_q;
  assign lsu_eff  = lsu_busy_q;
`endif

  logic hazard, accept, drain_done;
  logic [NREG-1:0] set_mask;

  always_comb begin
    hazard = 1'b0;
    if (use_rs1 && (rs1 != 5'd0) && pend_eff[rs1]) hazard = 1'b1;
    if (use_rs2 && (rs2 != 5'd0) && pend_eff[rs2]) hazard = 1'b1;
    if (use_rd  && (rd  != 5'd0) && pend_eff[rd])  hazard = 1'b1;
    if (is_lsu && lsu_eff)                         hazard = 1'b1;
  end

  assign bus_io.dec_ready = !rst && (state_q == StRun) && !bus_io.flush && !hazard &&
                            (!iss_valid_q || bus_io.iss_ready);
  assign accept     = bus_io.dec_valid && bus_io.dec_ready;
  assign set_mask   = (accept && use_rd && (rd != 5'd0)) ? (NREG'(1) << rd) : '0;
  assign drain_done = (pend_eff == '0) && !lsu_eff;

  always_comb begin
    // Set is ORed after clear so a same-cycle set of the written-back register wins
    pending_d   = (pending_q & ~wb_clr) | set_mask;
    lsu_busy_d  = (lsu_busy_q & ~bus_io.lsu_done) | (accept && is_lsu);
    iss_valid_d = iss_valid_q;
    iss_instr_d = iss_instr_q;
    iss_fu_d    = iss_fu_q;
    state_d     = state_q;

    if (bus_io.flush) begin
      iss_valid_d = 1'b0;
    end else if (accept) begin
      iss_valid_d = 1'b1;
      iss_instr_d = bus_io.dec_instr;
      iss_fu_d    = fu;
    end else if (bus_io.iss_ready) begin
      iss_valid_d = 1'b0;
    end

    case (state_q)
      StRun:   if (bus_io.flush) state_d = StDrain;
      StDrain: if (!bus_io.flush && drain_done) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      pending_q   <= '0;
      lsu_busy_q  <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_instr_q <= '0;
      iss_fu_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      lsu_busy_q  <= lsu_busy_d;
      iss_valid_q <= iss_valid_d;
      iss_instr_q <= iss_instr_d;
      iss_fu_q    <= iss_fu_d;
    end
  end

  assign bus_io.iss_valid  = iss_valid_q;
  assign bus_io.iss_instr  = iss_instr_q;
  assign bus_io.iss_fu     = iss_fu_q;
  assign bus_io.sb_pending = pending_q;
  assign bus_io.sb_busy    = (|pending_q) || lsu_busy_q || (state_q == StDrain);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: accepted instructions push their hand-computed
// expected {fu, instr}; a monitor pops and compares on every issue handshake.
module tb_issue_scoreboard;

`ifdef SB_BYPASS_EN
  localparam int Byp = 1;
`else
  localparam int Byp = 0;
`endif

  localparam logic [31:0] AddiX1 = 32'h0010_0093;  // addi x1,x0,1
  localparam logic [31:0] AddiX2 = 32'h0020_0113;  // addi x2,x0,2
  localparam logic [31:0] AddiX5 = 32'h0050_0293;  // addi x5,x0,5
  localparam logic [31:0] LwX5   = 32'h0000_2283;  // lw x5,0(x0)
  localparam logic [31:0] AddX6  = 32'h0002_8333;  // add x6,x5,x0
  localparam logic [31:0] SwX1   = 32'h0010_2023;  // sw x1,0(x0)
  localparam logic [31:0] LwX7   = 32'h0000_2383;  // lw x7,0(x0)
  localparam logic [31:0] Ill7f  = 32'h0000_007F;
  localparam logic [31:0] AddX0  = 32'h0010_8033;  // add x0,x1,x1

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_scoreboard_if bus ();

  issue_scoreboard dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer an instruction until accepted; returns number of stalled cycles
  task automatic offer(input logic [31:0] instr, input logic [1:0] fu, output int stalls);
    bit done = 0;
    stalls = 0;
    bus.dec_valid = 1'b1;
    bus.dec_instr = instr;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.dec_ready) begin
        exp_q.push_back({fu, instr});
        done = 1;
      end
      step();
      if (done) break;
      stalls++;
    end
    bus.dec_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: instr 0x%0h never accepted", instr);
    end
  endtask

  task automatic wb(input logic [4:0] rd);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    step();
    bus.wb_valid = 1'b0;
  endtask

  task automatic lsu_pulse();
    bus.lsu_done = 1'b1;
    step();
    bus.lsu_done = 1'b0;
  endtask

  // Issue monitor
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (bus.iss_valid && bus.iss_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got 0x%0h expected none", bus.iss_instr);
        end else begin
          e = exp_q.pop_front();
          check("issue_instr", bus.iss_instr, e[31:0]);
          check("issue_fu", {30'd0, bus.iss_fu}, {30'd0, e[33:32]});
        end
      end
    end
  end

  initial begin
    int st;
    bus.dec_valid = 1'b1;
    bus.dec_instr = AddiX1;
    bus.iss_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.lsu_done  = 1'b0;
    bus.flush     = 1'b0;

    // Reset
    repeat (2) step();
    @(negedge clk);
    check("ready_in_reset", {31'd0, bus.dec_ready}, 32'd0);
    step();
    rst = 1'b0;
    bus.dec_valid = 1'b0;
    @(negedge clk);
    check("rst_pending", bus.sb_pending, 32'd0);
    check("rst_iss_valid", {31'd0, bus.iss_valid}, 32'd0);
    check("rst_iss_instr", bus.iss_instr, 32'd0);
    check("rst_iss_fu", {30'd0, bus.iss_fu}, 32'd0);
    check("rst_busy", {31'd0, bus.sb_busy}, 32'd0);
    step();

    // 1: back-to-back independent
    bus.iss_ready = 1'b1;
    offer(AddiX1, 2'b00, st);
    check("t1_stall_a", st, 0);
    offer(AddiX2, 2'b00, st);
    check("t1_stall_b", st, 0);
    @(negedge clk);
    check("t1_pending", bus.sb_pending, 32'h6);
    step();
    wb(5'd1);
    wb(5'd2);
    @(negedge clk);
    check("t1_cleared", bus.sb_pending, 32'h0);
    step();

    // 2: RAW on load result
    offer(LwX5, 2'b01, st);
    fork
      offer(AddX6, 2'b00, st);
      begin
        repeat (3) @(posedge clk);
        #1 bus.wb_valid = 1'b1;
        bus.wb_rd = 5'd5;
        @(posedge clk);
        #1 bus.wb_valid = 1'b0;
      end
    join
    check("t2_raw_stall", st, 4 - Byp);
    @(negedge clk);
    check("t2_pending", bus.sb_pending, 32'h40);
    step();
    wb(5'd6);
    lsu_pulse();

    // 3: LSU busy
    offer(SwX1, 2'b01, st);
    check("t3_sw_stall", st, 0);
    @(negedge clk);
    check("t3_sw_no_pending", bus.sb_pending, 32'h0);
    check("t3_busy", {31'd0, bus.sb_busy}, 32'd1);
    step();
    fork
      offer(LwX7, 2'b01, st);
      begin
        repeat (3) @(posedge clk);
        #1 bus.lsu_done = 1'b1;
        @(posedge clk);
        #1 bus.lsu_done = 1'b0;
      end
    join
    check("t3_lsu_stall", st, 4 - Byp);
    wb(5'd7);
    lsu_pulse();
    @(negedge clk);
    check("t3_idle", {31'd0, bus.sb_busy}, 32'd0);
    step();

    // 4: issue backpressure
    bus.iss_ready = 1'b0;
    offer(AddiX1, 2'b00, st);
    bus.dec_valid = 1'b1;
    bus.dec_instr = AddiX2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_ready_low", {31'd0, bus.dec_ready}, 32'd0);
      check("t4_valid_held", {31'd0, bus.iss_valid}, 32'd1);
      check("t4_instr_held", bus.iss_instr, AddiX1);
      step();
    end
    bus.iss_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_release", {31'd0, bus.dec_ready}, 32'd1);
    if (bus.dec_ready) exp_q.push_back({2'b00, AddiX2});
    step();
    bus.dec_valid = 1'b0;
    step();
    wb(5'd1);
    wb(5'd2);

    // 5: flush and drain
    bus.iss_ready = 1'b0;
    offer(AddiX5, 2'b00, st);
    bus.flush     = 1'b1;
    bus.dec_valid = 1'b1;
    bus.dec_instr = AddiX1;
    @(negedge clk);
    check("t5_flush_ready", {31'd0, bus.dec_ready}, 32'd0);
    step();
    bus.flush = 1'b0;
    exp_q.delete();  // flushed instruction never reaches execute
    @(negedge clk);
    check("t5_iss_dropped", {31'd0, bus.iss_valid}, 32'd0);
    check("t5_drain_ready", {31'd0, bus.dec_ready}, 32'd0);
    check("t5_drain_busy", {31'd0, bus.sb_busy}, 32'd1);
    check("t5_pending", bus.sb_pending, 32'h20);
    step();
    bus.dec_valid = 1'b0;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd5;
    @(negedge clk);
    check("t5_wb_cycle_ready", {31'd0, bus.dec_ready}, 32'd0);
    step();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    check("t5_exit_ready", {31'd0, bus.dec_ready}, Byp);
    check("t5_exit_busy", {31'd0, bus.sb_busy}, 1 - Byp);
    step();
    @(negedge clk);
    check("t5_run_ready", {31'd0, bus.dec_ready}, 32'd1);
    check("t5_run_busy", {31'd0, bus.sb_busy}, 32'd0);
    step();
    bus.iss_ready = 1'b1;

    // 6: illegal opcode, rd=x0, wb to x0
    offer(Ill7f, 2'b11, st);
    check("t6_ill_stall", st, 0);
    offer(AddX0, 2'b00, st);
    check("t6_x0_stall", st, 0);
    @(negedge clk);
    check("t6_pending", bus.sb_pending, 32'h0);
    step();
    wb(5'd0);
    @(negedge clk);
    check("t6_wb_x0", bus.sb_pending, 32'h0);
    check("t6_busy", {31'd0, bus.sb_busy}, 32'd0);
    step();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
